// File: rtl/hams_sorted_serializer.sv
// Sorted-vector serializer: a two-slot ping-pong buffer of full sorted vectors
// drained one element per cycle in ascending index order, with a sticky
// overflow flag for vectors that arrive while both slots are occupied.

package hams_pkg;
  localparam int unsigned NUM_ELEMENTS = 8;

  typedef struct packed {
    logic [7:0] key;
    logic [7:0] data;
  } pair;
endpackage

module hams_sorted_serializer
  import hams_pkg::*;
#(
  localparam int unsigned IDX_W = $clog2(NUM_ELEMENTS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  pair [NUM_ELEMENTS-1:0] sorted,
  input  logic                   valid,
  output logic                   ready_o,
  output pair                    out_elem,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic [IDX_W-1:0]       out_idx,
  output logic                   overflow,
  input  logic                   clear_ovf
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ELEMENTS - 1);

  occ_t                   count;
  logic                   wp;
  logic                   rp;
  logic [IDX_W-1:0]       idx;
  pair [NUM_ELEMENTS-1:0] slot [2];

  logic accept;
  logic handshake;
  logic rel;
  logic drop;

  // Handshake decode; ready_o depends on registered occupancy only, so a
  // release in the FULL state never frees a slot in the same cycle.
  always_comb begin
    ready_o   = (count != FULL);
    out_valid = (count != EMPTY);
    out_elem  = slot[rp][idx];
    out_idx   = idx;
    out_last  = out_valid && (idx == LAST_IDX);
    accept    = valid && ready_o;
    handshake = out_valid && out_ready;
    rel       = handshake && (idx == LAST_IDX);
    drop      = valid && !ready_o;
  end

  // Occupancy FSM, pointers, element index and sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= EMPTY;
      wp       <= 1'b0;
      rp       <= 1'b0;
      idx      <= '0;
      overflow <= 1'b0;
    end else begin
      if (accept) begin
        wp <= ~wp;
      end

      if (handshake) begin
        if (idx == LAST_IDX) begin
          idx <= '0;
          rp  <= ~rp;
        end else begin
          idx <= idx + IDX_W'(1);
        end
      end

      unique case (count)
        EMPTY: begin
          if (accept) count <= ONE;
        end
        ONE: begin
          if (accept && !rel)      count <= FULL;
          else if (rel && !accept) count <= EMPTY;
        end
        FULL: begin
          if (rel) count <= ONE;
        end
        default: count <= EMPTY;
      endcase

      // A drop in the same cycle as a clear keeps the flag set.
      if (drop) begin
        overflow <= 1'b1;
      end else if (clear_ovf) begin
        overflow <= 1'b0;
      end
    end
  end

  // Vector storage; deliberately not reset, contents are only observed while
  // out_valid is high.
  always_ff @(posedge clk) begin
    if (accept) begin
      slot[wp] <= sorted;
    end
  end

endmodule

// File: tb/tb_hams_sorted_serializer.sv
// Randomized scoreboard bench for hams_sorted_serializer. The stimulus process
// drives inputs shortly after each rising edge and pushes the expected element
// stream of every vector the model predicts will be accepted; the monitor
// samples on the falling edge and checks each presented element.

module tb_hams_sorted_serializer;
  import hams_pkg::*;

  localparam int unsigned IW = $clog2(NUM_ELEMENTS);

  logic                   clk;
  logic                   rst_n;
  pair [NUM_ELEMENTS-1:0] sorted;
  logic                   valid;
  logic                   ready_o;
  pair                    out_elem;
  logic                   out_valid;
  logic                   out_ready;
  logic                   out_last;
  logic [IW-1:0]          out_idx;
  logic                   overflow;
  logic                   clear_ovf;

  hams_sorted_serializer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sorted    (sorted),
    .valid     (valid),
    .ready_o   (ready_o),
    .out_elem  (out_elem),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .out_idx   (out_idx),
    .overflow  (overflow),
    .clear_ovf (clear_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    pair         e;
    int unsigned idx;
    bit          last;
  } exp_t;

  // Reference model: a FIFO of expected elements for vectors inside the DUT,
  // a count of vectors not yet fully drained, and the expected overflow flag.
  exp_t                   q[$];
  int                     vec_count;
  bit                     pend_valid;
  pair [NUM_ELEMENTS-1:0] pend_vec;
  bit                     model_ovf;
  bit                     pend_ovf;

  int n_vec;
  int n_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic pair [NUM_ELEMENTS-1:0] rand_vec();
    pair [NUM_ELEMENTS-1:0] v;
    int k;
    k = int'($urandom_range(0, 31));
    for (int i = 0; i < int'(NUM_ELEMENTS); i++) begin
      v[i].key  = 8'(k);
      v[i].data = 8'($urandom);
      k += int'($urandom_range(0, 15));
    end
    return v;
  endfunction

  // Monitor: compares whatever the DUT presents against the head of the FIFO.
  always @(negedge clk) begin
    if (rst_n) begin
      exp_t h;
      check("out_valid", 32'(out_valid), 32'(q.size() != 0));
      if (out_valid && q.size() != 0) begin
        h = q[0];
        check("out_elem", 32'(out_elem), 32'(h.e));
        check("out_idx", 32'(out_idx), h.idx);
        check("out_last", 32'(out_last), 32'(h.last));
        if (out_ready) begin
          void'(q.pop_front());
          if (h.last) vec_count--;
        end
      end
      check("overflow", 32'(overflow), 32'(model_ovf));
    end
  end

  // One stimulus cycle: commit last cycle's predicted accept, check ready_o,
  // then drive new random inputs with the given percentages.
  task automatic cycle(input int vp, input int rp_pct);
    bit rdy;
    @(posedge clk);
    #2;
    if (pend_valid) begin
      for (int i = 0; i < int'(NUM_ELEMENTS); i++) begin
        exp_t x;
        x.e    = pend_vec[i];
        x.idx  = i;
        x.last = (i == int'(NUM_ELEMENTS) - 1);
        q.push_back(x);
      end
      vec_count++;
      pend_valid = 1'b0;
    end
    model_ovf = pend_ovf;
    rdy = (vec_count < 2);
    check("ready_o", 32'(ready_o), 32'(rdy));

    valid     = (int'($urandom_range(0, 99)) < vp);
    sorted    = rand_vec();
    out_ready = (int'($urandom_range(0, 99)) < rp_pct);
    clear_ovf = ($urandom_range(0, 99) < 8);
    if (valid && rdy) begin
      pend_valid = 1'b1;
      pend_vec   = sorted;
    end
    pend_ovf = (valid && !rdy) ? 1'b1 : (clear_ovf ? 1'b0 : model_ovf);
  endtask

  // Asynchronous reset applied mid-cycle; a vector is offered immediately
  // after release so it is accepted on the first following edge.
  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n     = 1'b0;
    valid     = 1'b0;
    clear_ovf = 1'b0;
    #1;
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst ready_o", 32'(ready_o), 32'd1);
    check("rst out_idx", 32'(out_idx), 32'd0);
    check("rst out_last", 32'(out_last), 32'd0);
    check("rst overflow", 32'(overflow), 32'd0);
    q.delete();
    vec_count  = 0;
    pend_valid = 1'b0;
    model_ovf  = 1'b0;
    pend_ovf   = 1'b0;
    @(posedge clk);
    #2;
    rst_n      = 1'b1;
    valid      = 1'b1;
    out_ready  = 1'b1;
    sorted     = rand_vec();
    pend_valid = 1'b1;
    pend_vec   = sorted;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit found;
    n_vec     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    valid     = 1'b0;
    out_ready = 1'b0;
    clear_ovf = 1'b0;
    sorted    = '0;
    vec_count = 0;
    pend_valid = 1'b0;
    model_ovf = 1'b0;
    pend_ovf  = 1'b0;
    #3;
    check("init out_valid", 32'(out_valid), 32'd0);
    check("init ready_o", 32'(ready_o), 32'd1);
    check("init overflow", 32'(overflow), 32'd0);
    do_reset();

    for (int i = 0; i < 300; i++) cycle(60, 100);
    for (int i = 0; i < 300; i++) cycle(90, 30);
    for (int i = 0; i < 20; i++)  cycle(100, 0);
    for (int i = 0; i < 200; i++) cycle(20, 90);
    for (int i = 0; i < 300; i++) cycle(100, 100);
    for (int i = 0; i < 300; i++) cycle(70, 60);

    // Reset while the current vector is part-way through its drain.
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      cycle(30, 100);
      found = out_valid && (out_idx == IW'(5));
    end
    check("reach idx5", 32'(found), 32'd1);
    do_reset();

    for (int i = 0; i < 200; i++) cycle(50, 80);
    for (int i = 0; i < 40; i++)  cycle(0, 100);
    @(negedge clk);
    check("final drain", 32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
